// File: rtl/frame_sync_controller.sv
// -----------------------------------------------------------------------------
// frame_sync_controller
//   Frame-alignment controller for the lpGBT receive path. It watches the 2-bit
//   header delivered by the bit-slip extractor. It slips the frame one bit later
//   until the header is stable. It then raises d_enb to release aligned data to
//   the descrambler, and it supervises the lock from then on.
//
// Ports
//   i_clk             receive clock, shared with the extractor
//   i_rst             synchronous reset, active-high
//   i_align_en        1 = alignment allowed, 0 = hold in HUNT without slipping
//   i_pattern[1:0]    header bits at the current slip offset
//   o_shift_fr_later  one-cycle slip request to the extractor
//   o_d_enb           aligned flag / data enable, high only in LOCKED
//   o_sync_state[1:0] 0=HUNT 1=SETTLE 2=CONFIRM 3=LOCKED
//   o_slip_cnt[4:0]   shadow of the extractor shift counter, wraps 31->0
//   o_sweep_done      one-cycle pulse in the cycle slip_cnt reads 0 after a wrap
//   o_hdr_err_cnt     invalid headers seen while LOCKED, saturating
//   o_unlock_cnt      LOCKED->HUNT transitions, saturating
// -----------------------------------------------------------------------------
module frame_sync_controller #(
  parameter logic [1:0]  HDR_A         = 2'b10,
  parameter logic [1:0]  HDR_B         = 2'b01,
  parameter int unsigned LOCK_COUNT    = 32,
  parameter int unsigned UNLOCK_COUNT  = 4,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_align_en,
  input  logic [1:0]  i_pattern,
  output logic        o_shift_fr_later,
  output logic        o_d_enb,
  output logic [1:0]  o_sync_state,
  output logic [4:0]  o_slip_cnt,
  output logic        o_sweep_done,
  output logic [15:0] o_hdr_err_cnt,
  output logic [7:0]  o_unlock_cnt
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam int WW = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    SETTLE  = 2'd1,
    CONFIRM = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  function automatic logic is_valid(input logic [1:0] p);
    return (p == HDR_A) || (p == HDR_B);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      r_state,       w_state_nxt;
  logic [GW-1:0] r_good_cnt,  w_good_nxt;
  logic [BW-1:0] r_bad_cnt,   w_bad_nxt;
  logic [WW-1:0] r_wait_cnt,  w_wait_nxt;
  logic [4:0]  r_slip_cnt,    w_slip_nxt;
  logic [15:0] r_hdr_err_cnt, w_hdr_err_nxt;
  logic [7:0]  r_unlock_cnt,  w_unlock_nxt;
  logic        r_shift,       w_shift_nxt;
  logic        r_sweep,       w_sweep_nxt;
  logic        r_d_enb,       w_d_enb_nxt;
  logic        w_valid;
  logic        w_slip_req;
  logic [GW-1:0] w_good_inc;
  logic [BW-1:0] w_bad_inc;

  assign w_valid    = is_valid(i_pattern);
  assign w_good_inc = r_good_cnt + GW'(1);
  assign w_bad_inc  = r_bad_cnt + BW'(1);

  // State and output register; every output comes straight from a flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= HUNT;
      r_good_cnt    <= '0;
      r_bad_cnt     <= '0;
      r_wait_cnt    <= '0;
      r_slip_cnt    <= 5'd0;
      r_hdr_err_cnt <= 16'd0;
      r_unlock_cnt  <= 8'd0;
      r_shift       <= 1'b0;
      r_sweep       <= 1'b0;
      r_d_enb       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_good_cnt    <= w_good_nxt;
      r_bad_cnt     <= w_bad_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_slip_cnt    <= w_slip_nxt;
      r_hdr_err_cnt <= w_hdr_err_nxt;
      r_unlock_cnt  <= w_unlock_nxt;
      r_shift       <= w_shift_nxt;
      r_sweep       <= w_sweep_nxt;
      r_d_enb       <= w_d_enb_nxt;
    end
  end

  // Next-state and next-output logic for the alignment FSM.
  always_comb begin
    w_state_nxt   = r_state;
    w_good_nxt    = r_good_cnt;
    w_bad_nxt     = r_bad_cnt;
    w_wait_nxt    = r_wait_cnt;
    w_slip_nxt    = r_slip_cnt;
    w_hdr_err_nxt = r_hdr_err_cnt;
    w_unlock_nxt  = r_unlock_cnt;
    w_shift_nxt   = 1'b0;
    w_sweep_nxt   = 1'b0;
    w_slip_req    = 1'b0;

    case (r_state)
      HUNT: begin
        w_good_nxt = '0;
        w_bad_nxt  = '0;
        w_wait_nxt = '0;
        if (!i_align_en) begin
          w_state_nxt = HUNT;
        end else if (w_valid) begin
          // The HUNT sample already counts as the first good header.
          w_good_nxt  = GW'(1);
          w_state_nxt = (LOCK_COUNT == 1) ? LOCKED : CONFIRM;
        end else begin
          w_slip_req = 1'b1;
        end
      end

      SETTLE: begin
        // The extractor output is still moving; the header is not looked at here.
        if (r_wait_cnt == WW'(SETTLE_CYCLES - 1)) begin
          w_wait_nxt  = '0;
          w_state_nxt = HUNT;
        end else begin
          w_wait_nxt = r_wait_cnt + WW'(1);
        end
      end

      CONFIRM: begin
        if (!i_align_en) begin
          w_good_nxt  = '0;
          w_state_nxt = HUNT;
        end else if (w_valid) begin
          if (w_good_inc == GW'(LOCK_COUNT)) begin
            w_good_nxt  = '0;
            w_bad_nxt   = '0;
            w_state_nxt = LOCKED;
          end else begin
            w_good_nxt = w_good_inc;
          end
        end else begin
          w_slip_req = 1'b1;
        end
      end

      LOCKED: begin
        if (w_valid) begin
          w_bad_nxt = '0;
        end else begin
          w_hdr_err_nxt = sat_inc16(r_hdr_err_cnt);
          if (w_bad_inc == BW'(UNLOCK_COUNT)) begin
            // Drop back to HUNT without slipping; HUNT decides whether to slip.
            w_bad_nxt    = '0;
            w_unlock_nxt = sat_inc8(r_unlock_cnt);
            w_state_nxt  = HUNT;
          end else begin
            w_bad_nxt = w_bad_inc;
          end
        end
      end

      default: begin
        w_state_nxt = HUNT;
      end
    endcase

    // A slip always goes through SETTLE, so two pulses can never be adjacent.
    if (w_slip_req) begin
      w_shift_nxt = 1'b1;
      w_slip_nxt  = r_slip_cnt + 5'd1;
      w_sweep_nxt = (r_slip_cnt == 5'd31);
      w_good_nxt  = '0;
      w_wait_nxt  = '0;
      w_state_nxt = SETTLE;
    end else begin
      w_shift_nxt = 1'b0;
    end

    w_d_enb_nxt = (w_state_nxt == LOCKED);
  end

  assign o_shift_fr_later = r_shift;
  assign o_d_enb          = r_d_enb;
  assign o_sync_state     = r_state;
  assign o_slip_cnt       = r_slip_cnt;
  assign o_sweep_done     = r_sweep;
  assign o_hdr_err_cnt    = r_hdr_err_cnt;
  assign o_unlock_cnt     = r_unlock_cnt;

endmodule

// File: tb/tb_frame_sync_controller.sv
// -----------------------------------------------------------------------------
// tb_frame_sync_controller
//   Directed bench for frame_sync_controller with hand-computed expectations.
//   A tiny extractor model (offset tracked from the slip pulses) supplies the
//   header when model_on is set.
// -----------------------------------------------------------------------------
module tb_frame_sync_controller;

  logic        clk;
  logic        rst;
  logic        align_en;
  logic [1:0]  pattern;
  logic        shift_fr_later;
  logic        d_enb;
  logic [1:0]  sync_state;
  logic [4:0]  slip_cnt;
  logic        sweep_done;
  logic [15:0] hdr_err_cnt;
  logic [7:0]  unlock_cnt;

  int errors = 0;
  int checks = 0;

  // bookkeeping updated by tick()
  int tick_no    = 0;
  int pulses     = 0;
  int dbl_pulses = 0;
  int sweeps     = 0;
  int sweep_tick = 0;
  int sweep_slip = -1;
  int last_pulse = 0;
  int min_gap    = 1000;
  int lock_tick  = 0;
  int offset     = 0;
  bit model_on   = 1'b0;
  bit prev_shift = 1'b0;

  frame_sync_controller dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_align_en       (align_en),
    .i_pattern        (pattern),
    .o_shift_fr_later (shift_fr_later),
    .o_d_enb          (d_enb),
    .o_sync_state     (sync_state),
    .o_slip_cnt       (slip_cnt),
    .o_sweep_done     (sweep_done),
    .o_hdr_err_cnt    (hdr_err_cnt),
    .o_unlock_cnt     (unlock_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    tick_no    = 0;
    pulses     = 0;
    dbl_pulses = 0;
    sweeps     = 0;
    sweep_tick = 0;
    sweep_slip = -1;
    last_pulse = 0;
    min_gap    = 1000;
    lock_tick  = 0;
    offset     = 0;
    prev_shift = 1'b0;
  endtask

  // One clock: sample 1 time unit after the edge, then update the model.
  task automatic tick();
    @(posedge clk);
    #1;
    tick_no++;
    if (shift_fr_later) begin
      pulses++;
      if (last_pulse != 0 && (tick_no - last_pulse) < min_gap) min_gap = tick_no - last_pulse;
      last_pulse = tick_no;
      offset = (offset + 1) % 32;
    end
    if (prev_shift && shift_fr_later) dbl_pulses++;
    prev_shift = shift_fr_later;
    if (sweep_done) begin
      sweeps++;
      sweep_tick = tick_no;
      sweep_slip = slip_cnt;
    end
    if (d_enb && lock_tick == 0) lock_tick = tick_no;
    if (model_on) pattern = (offset == 7) ? 2'b10 : 2'b00;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, sync_state, 0);
    chk({tag, "_denb"},  d_enb, 0);
    chk({tag, "_shift"}, shift_fr_later, 0);
    chk({tag, "_slip"},  slip_cnt, 0);
    chk({tag, "_sweep"}, sweep_done, 0);
    chk({tag, "_herr"},  hdr_err_cnt, 0);
    chk({tag, "_unl"},   unlock_cnt, 0);
  endtask

  initial begin
    rst      = 1'b1;
    align_en = 1'b1;
    pattern  = 2'b10;

    // ---- reset state ----
    rst = 1'b1;
    ticks(2);
    chk_reset_vals("rst0");

    // ---- 1) fixed valid header: lock after 32 samples, no slips ----
    rst = 1'b0;
    clear_stats();
    ticks(31);
    chk("t1_denb_c31", d_enb, 0);
    chk("t1_state_c31", sync_state, 2);
    tick();
    chk("t1_denb_c32", d_enb, 1);
    chk("t1_state_c32", sync_state, 3);
    chk("t1_slip", slip_cnt, 0);
    chk("t1_pulses", pulses, 0);

    // ---- 3) three invalid headers while locked: stays locked ----
    pattern = 2'b00;
    ticks(3);
    chk("t3_denb_bad3", d_enb, 1);
    chk("t3_herr_bad3", hdr_err_cnt, 3);
    pattern = 2'b10;
    tick();
    chk("t3_denb", d_enb, 1);
    chk("t3_herr", hdr_err_cnt, 3);
    chk("t3_unl", unlock_cnt, 0);

    // ---- 4) four invalid headers: unlock, then relock at the same offset ----
    clear_stats();
    pattern = 2'b00;
    ticks(3);
    chk("t4_denb_bad3", d_enb, 1);
    tick();
    chk("t4_denb_bad4", d_enb, 0);
    chk("t4_state_bad4", sync_state, 0);
    chk("t4_unl", unlock_cnt, 1);
    chk("t4_herr", hdr_err_cnt, 7);
    pattern = 2'b10;
    ticks(31);
    chk("t4_relock_c31", d_enb, 0);
    tick();
    chk("t4_relock_c32", d_enb, 1);
    chk("t4_relock_slip", slip_cnt, 0);
    chk("t4_relock_pulses", pulses, 0);

    // ---- 2) extractor model, valid header only at offset 7 ----
    pattern = 2'b00;
    do_reset();
    clear_stats();
    model_on = 1'b1;
    pattern  = 2'b00;
    ticks(80);
    model_on = 1'b0;
    chk("t2_pulses", pulses, 7);
    chk("t2_min_gap", min_gap, 5);
    chk("t2_dbl", dbl_pulses, 0);
    chk("t2_lock_tick", lock_tick, 67);
    chk("t2_slip", slip_cnt, 7);
    chk("t2_denb", d_enb, 1);
    chk("t2_state", sync_state, 3);

    // ---- 6a) reset mid-CONFIRM with good_cnt=20 ----
    pattern = 2'b10;
    do_reset();
    ticks(20);
    chk("t6a_state_pre", sync_state, 2);
    rst = 1'b1;
    tick();
    chk_reset_vals("t6a");
    rst = 1'b0;
    ticks(31);
    chk("t6a_relock_c31", d_enb, 0);
    tick();
    chk("t6a_relock_c32", d_enb, 1);

    // ---- 6b) align_en low holds HUNT without slips ----
    align_en = 1'b0;
    pattern  = 2'b00;
    do_reset();
    clear_stats();
    ticks(20);
    chk_reset_vals("t6b");
    pattern = 2'b10;
    ticks(5);
    chk("t6b_valid_state", sync_state, 0);
    chk("t6b_pulses", pulses, 0);
    // align_en dropping in CONFIRM returns to HUNT without a slip
    align_en = 1'b1;
    ticks(5);
    chk("t6b_confirm", sync_state, 2);
    align_en = 1'b0;
    tick();
    chk("t6b_abort_state", sync_state, 0);
    chk("t6b_abort_pulse", shift_fr_later, 0);

    // ---- 5) header held at 2'b00: full sweep and wrap ----
    align_en = 1'b1;
    pattern  = 2'b00;
    do_reset();
    clear_stats();
    ticks(165);
    chk("t5_pulses", pulses, 33);
    chk("t5_sweeps", sweeps, 1);
    chk("t5_sweep_tick", sweep_tick, 156);
    chk("t5_sweep_slip", sweep_slip, 0);
    chk("t5_final_slip", slip_cnt, 1);
    chk("t5_min_gap", min_gap, 5);
    chk("t5_dbl", dbl_pulses, 0);

    // ---- unlock counter saturation ----
    do_reset();
    for (int i = 0; i < 254; i++) begin
      pattern = 2'b10;
      ticks(32);
      pattern = 2'b00;
      ticks(4);
    end
    chk("sat_unl_254", unlock_cnt, 254);
    for (int i = 0; i < 6; i++) begin
      pattern = 2'b10;
      ticks(32);
      pattern = 2'b00;
      ticks(4);
    end
    chk("sat_unl_255", unlock_cnt, 255);
    chk("sat_herr", hdr_err_cnt, 1040);
    chk("sat_state", sync_state, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
